// File: rtl/prbs15_wide_checker.sv
// prbs15_wide_checker: self-synchronising wide PRBS15 checker with lock FSM and saturating error counters
// Ports:
//   clk_i             rising-edge clock
//   rst_n_i           asynchronous active-low reset
//   data_in_i         received word, bit 0 oldest in time
//   data_valid_i      data_in_i valid this cycle; invalid cycles are ignored
//   clear_i           synchronous clear of both error counters (wins over increment)
//   locked_o          high while in LOCKED
//   err_flag_o        one-cycle pulse: previous valid word mismatched (not in PRIME)
//   err_count_o       saturating mismatched-bit count while LOCKED
//   err_word_count_o  saturating errored-word count while LOCKED
module prbs15_wide_checker #(
  parameter int WIDTH    = 20,
  parameter int TAP1     = 15,
  parameter int TAP2     = 14,
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             data_valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_flag_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] err_word_count_o
);
  localparam int PW = $clog2(WIDTH + 1);
  localparam int RW = $clog2((LOCK_CNT > LOSS_CNT ? LOCK_CNT : LOSS_CNT) + 1);
  localparam int SW = (CNT_W > PW ? CNT_W : PW) + 1;
  typedef enum logic [1:0] {PRIME, HUNT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] hist_q, hist_d, err;
  logic [2*WIDTH-1:0] c;
  logic [PW-1:0] pop;
  logic werr, cnt_en, flag_q, flag_d;
  logic [RW-1:0] good_q, good_d, bad_q, bad_d, good_nx, bad_nx;
  logic [CNT_W-1:0] ec_q, ec_d, wc_q, wc_d;
  logic [SW-1:0] ec_sum, wc_sum;
  logic unused_c;
  // oldest hist bits below WIDTH-TAP1 never feed a prediction
  assign c = {data_in_i, hist_q};
  assign unused_c = ^c;
  // each bit is predicted from received bits, so the checker resynchronises on its own
  always_comb begin
    err = '0;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      err[i] = data_in_i[i] ^ c[WIDTH+i-TAP1] ^ c[WIDTH+i-TAP2];
      pop = pop + PW'(err[i]);
    end
  end
  assign werr    = |err;
  assign good_nx = werr ? '0 : good_q + 1'b1;
  assign bad_nx  = werr ? bad_q + 1'b1 : '0;
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (data_valid_i)
      case (state_q)
        PRIME: begin
          state_d = HUNT;
          good_d  = '0;
        end
        HUNT: begin
          good_d = good_nx;
          if (good_nx == RW'(LOCK_CNT)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end
        end
        LOCKED: begin
          bad_d = bad_nx;
          if (bad_nx == RW'(LOSS_CNT)) begin
            state_d = HUNT;
            good_d  = '0;
            bad_d   = '0;
          end
        end
        default: state_d = PRIME;
      endcase
  end
  assign hist_d = data_valid_i ? data_in_i : hist_q;
  assign flag_d = data_valid_i && state_q != PRIME && werr;
  assign cnt_en = data_valid_i && state_q == LOCKED;
  assign ec_sum = SW'(ec_q) + SW'(pop);
  assign wc_sum = SW'(wc_q) + SW'(werr);
  assign ec_d = clear_i ? '0 : !cnt_en ? ec_q : ec_sum > SW'({CNT_W{1'b1}}) ? '1 : CNT_W'(ec_sum);
  assign wc_d = clear_i ? '0 : !cnt_en ? wc_q : wc_sum > SW'({CNT_W{1'b1}}) ? '1 : CNT_W'(wc_sum);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= PRIME;
      hist_q  <= '1;
      good_q  <= '0;
      bad_q   <= '0;
      flag_q  <= 1'b0;
      ec_q    <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      flag_q  <= flag_d;
      ec_q    <= ec_d;
      wc_q    <= wc_d;
    end
  assign locked_o         = state_q == LOCKED;
  assign err_flag_o       = flag_q;
  assign err_count_o      = ec_q;
  assign err_word_count_o = wc_q;
endmodule

// File: tb/tb_prbs15_wide_checker.sv
// tb_prbs15_wide_checker: directed checks of lock, error counting, clear, gaps, async reset and saturation
module tb_prbs15_wide_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [19:0] data = '0;
  logic valid = 1'b0;
  logic clr = 1'b0;
  logic locked, flag, locked_b, flag_b;
  logic [31:0] ec, wc;
  logic [3:0] ec_b, wc_b;
  logic [14:0] g = '1;
  logic [19:0] w;
  int checks = 0;
  int failures = 0;
  int bad;
  always #5 clk = ~clk;
  prbs15_wide_checker dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(data), .data_valid_i(valid), .clear_i(clr),
    .locked_o(locked), .err_flag_o(flag), .err_count_o(ec), .err_word_count_o(wc)
  );
  prbs15_wide_checker #(.CNT_W(4), .LOSS_CNT(1000)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(data), .data_valid_i(valid), .clear_i(clr),
    .locked_o(locked_b), .err_flag_o(flag_b), .err_count_o(ec_b), .err_word_count_o(wc_b)
  );
  task automatic gen_word(output logic [19:0] o);
    logic b;
    for (int i = 0; i < 20; i++) begin
      b = g[0] ^ g[1];
      o[i] = b;
      g = {b, g[14:1]};
    end
  endtask
  task automatic cycle(input logic [19:0] d, input logic v, input logic c);
    @(negedge clk);
    data = d;
    valid = v;
    clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || flag !== 1'b0 || ec !== 32'd0 || wc !== 32'd0) begin
      failures++;
      $display("FAIL reset_a locked=%0b flag=%0b ec=%0d wc=%0d exp 0/0/0/0", locked, flag, ec, wc);
    end
    checks++;
    if (locked_b !== 1'b0 || flag_b !== 1'b0 || ec_b !== 4'd0 || wc_b !== 4'd0) begin
      failures++;
      $display("FAIL reset_b locked=%0b flag=%0b ec=%0d wc=%0d exp 0/0/0/0", locked_b, flag_b, ec_b, wc_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g = '1;
  endtask
  task automatic test_lock;
    for (int k = 1; k <= 9; k++) begin
      gen_word(w);
      cycle(w, 1'b1, 1'b0);
      if (k == 8) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL lock_early locked=%0b exp 0", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || flag !== 1'b0) begin
      failures++;
      $display("FAIL lock_at_9 locked=%0b flag=%0b exp 1/0", locked, flag);
    end
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      gen_word(w);
      cycle(w, 1'b1, 1'b0);
      if (flag !== 1'b0 || ec !== 32'd0 || wc !== 32'd0 || locked !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clean_1000 bad_words=%0d exp 0 (ec=%0d wc=%0d)", bad, ec, wc);
    end
  endtask
  task automatic test_single_flip;
    gen_word(w);
    cycle(w ^ 20'h00020, 1'b1, 1'b0);
    checks++;
    if (flag !== 1'b1 || locked !== 1'b1 || ec !== 32'd2 || wc !== 32'd1) begin
      failures++;
      $display("FAIL flip_word flag=%0b locked=%0b ec=%0d wc=%0d exp 1/1/2/1", flag, locked, ec, wc);
    end
    gen_word(w);
    cycle(w, 1'b1, 1'b0);
    checks++;
    if (flag !== 1'b1 || locked !== 1'b1 || ec !== 32'd3 || wc !== 32'd2) begin
      failures++;
      $display("FAIL flip_next flag=%0b locked=%0b ec=%0d wc=%0d exp 1/1/3/2", flag, locked, ec, wc);
    end
    gen_word(w);
    cycle(w, 1'b1, 1'b0);
    checks++;
    if (flag !== 1'b0 || locked !== 1'b1 || ec !== 32'd3 || wc !== 32'd2) begin
      failures++;
      $display("FAIL flip_after flag=%0b locked=%0b ec=%0d wc=%0d exp 0/1/3/2", flag, locked, ec, wc);
    end
  endtask
  task automatic test_clear;
    gen_word(w);
    cycle(w ^ 20'h00020, 1'b1, 1'b1);
    checks++;
    if (ec !== 32'd0 || wc !== 32'd0 || flag !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clear_prio ec=%0d wc=%0d flag=%0b locked=%0b exp 0/0/1/1", ec, wc, flag, locked);
    end
    gen_word(w);
    cycle(w, 1'b1, 1'b1);
    gen_word(w);
    cycle(w, 1'b1, 1'b0);
    checks++;
    if (ec !== 32'd0 || wc !== 32'd0 || flag !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clear_after ec=%0d wc=%0d flag=%0b locked=%0b exp 0/0/0/1", ec, wc, flag, locked);
    end
  endtask
  task automatic test_loss;
    bad = 0;
    for (int k = 1; k <= 4; k++) begin
      gen_word(w);
      cycle(w ^ 20'h00001, 1'b1, 1'b0);
      if (flag !== 1'b1 || (k < 4 && locked !== 1'b1)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL loss_run bad_words=%0d exp 0", bad);
    end
    checks++;
    if (locked !== 1'b0 || ec !== 32'd12 || wc !== 32'd4) begin
      failures++;
      $display("FAIL loss_exit locked=%0b ec=%0d wc=%0d exp 0/12/4", locked, ec, wc);
    end
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      gen_word(w);
      cycle(w, 1'b1, 1'b0);
      if (flag !== 1'b0 || (k < 8 && locked !== 1'b0)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL relock_hunt bad_words=%0d exp 0", bad);
    end
    checks++;
    if (locked !== 1'b1 || ec !== 32'd12 || wc !== 32'd4) begin
      failures++;
      $display("FAIL relock locked=%0b ec=%0d wc=%0d exp 1/12/4", locked, ec, wc);
    end
  endtask
  task automatic test_gaps;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    g = '1;
    bad = 0;
    for (int k = 1; k <= 29; k++) begin
      gen_word(w);
      cycle(w, 1'b1, 1'b0);
      if (k == 8) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL gap_lock_early locked=%0b exp 0", locked);
        end
      end
      if (k == 9) begin
        checks++;
        if (locked !== 1'b1) begin
          failures++;
          $display("FAIL gap_lock_at_9 locked=%0b exp 1", locked);
        end
      end
      if (k > 9 && locked !== 1'b1) bad++;
      cycle(20'hABCDE, 1'b0, 1'b0);
      if (flag !== 1'b0 || ec !== 32'd0 || wc !== 32'd0) bad++;
      cycle(20'h13579, 1'b0, 1'b0);
      if (flag !== 1'b0 || ec !== 32'd0 || wc !== 32'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL gap_hold bad_cycles=%0d exp 0", bad);
    end
    gen_word(w);
    cycle(w ^ 20'h00020, 1'b1, 1'b0);
    cycle(20'hFFFFF, 1'b0, 1'b0);
    checks++;
    if (flag !== 1'b0 || ec !== 32'd2 || wc !== 32'd1) begin
      failures++;
      $display("FAIL gap_flag flag=%0b ec=%0d wc=%0d exp 0/2/1", flag, ec, wc);
    end
    cycle(20'h00000, 1'b0, 1'b0);
    gen_word(w);
    cycle(w, 1'b1, 1'b0);
    checks++;
    if (flag !== 1'b1 || ec !== 32'd3 || wc !== 32'd2 || locked !== 1'b1) begin
      failures++;
      $display("FAIL gap_span flag=%0b ec=%0d wc=%0d locked=%0b exp 1/3/2/1", flag, ec, wc, locked);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || flag !== 1'b0 || ec !== 32'd0 || wc !== 32'd0) begin
      failures++;
      $display("FAIL async_reset locked=%0b flag=%0b ec=%0d wc=%0d exp 0/0/0/0", locked, flag, ec, wc);
    end
  endtask
  task automatic test_saturate;
    @(negedge clk);
    rst_n = 1'b1;
    g = '1;
    for (int k = 0; k < 9; k++) begin
      gen_word(w);
      cycle(w, 1'b1, 1'b0);
    end
    checks++;
    if (locked_b !== 1'b1 || ec_b !== 4'd0) begin
      failures++;
      $display("FAIL sat_lock locked=%0b ec=%0d exp 1/0", locked_b, ec_b);
    end
    for (int k = 1; k <= 16; k++) begin
      gen_word(w);
      cycle(w ^ 20'h00001, 1'b1, 1'b0);
      if (k == 5 || k == 6) begin
        checks++;
        if (ec_b !== 4'd15 || wc_b !== 4'(k)) begin
          failures++;
          $display("FAIL sat_bits_%0d ec=%0d wc=%0d exp 15/%0d", k, ec_b, wc_b, k);
        end
      end
    end
    checks++;
    if (ec_b !== 4'd15 || wc_b !== 4'd15 || locked_b !== 1'b1) begin
      failures++;
      $display("FAIL sat_words ec=%0d wc=%0d locked=%0b exp 15/15/1", ec_b, wc_b, locked_b);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_lock();
    test_single_flip();
    test_clear();
    test_loss();
    test_gaps();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
